// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clock_period_meter
// Description : Measures the period (rise to rise) and high phase (rise to
//               fall) of a slow asynchronous clock in system-clock cycles,
//               with lock tracking and a sticky stall flag.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic             sysclk,
  input  logic             resetn,
  input  logic             clkin,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic             rise_det_q, rise_det_d;
  logic             fall_det_q, fall_det_d;
  logic             rise_tick_q, rise_tick_d;
  logic             fall_tick_q, fall_tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;

  logic [CNT_W-1:0] elapsed;
  logic             timeout_hit;

  // Synchronizer, history and two-stage edge pipeline: a new clkin level
  // yields a tick three sysclk edges after it is first sampled.
  always_comb begin
    sync1_d     = clkin;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    rise_det_d  = sync2_q & ~hist_q;
    fall_det_d  = ~sync2_q & hist_q;
    rise_tick_d = rise_det_q;
    fall_tick_d = fall_det_q;
  end

  // Saturating elapsed time; the free counter restarts on every rise.
  always_comb begin
    elapsed     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    cnt_d       = rise_tick_q ? '0 : elapsed;
    timeout_hit = (cnt_q == TIMEOUT_LAST);
  end

  // Lock FSM next state and measurement updates; a rise always beats a
  // timeout, and a timeout beats a coincident fall (no latch on stall).
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    stalled_d   = stalled_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_tick_q) begin
          state_d   = ST_ARMED;
          stalled_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (rise_tick_q) begin
          period_d = elapsed;
          valid_d  = 1'b1;
          state_d  = ST_LOCKED;
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          stalled_d = 1'b1;
        end else if (fall_tick_q) begin
          high_time_d = elapsed;
        end
      end
      ST_LOCKED: begin
        if (rise_tick_q) begin
          period_d = elapsed;
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          stalled_d = 1'b1;
        end else if (fall_tick_q) begin
          high_time_d = elapsed;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers, cleared asynchronously while resetn is low.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      rise_det_q  <= 1'b0;
      fall_det_q  <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      rise_det_q  <= rise_det_d;
      fall_det_q  <= fall_det_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      stalled_q   <= stalled_d;
    end
  end

  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign stalled   = stalled_q;

endmodule
`default_nettype wire

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 100000000: number of sysclk cycles without a rising edge before the measurement is declared stalled; legal range 2..2^CNT_W-1.
REQ-003 sysclk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 clkin  input  1  slow clock to be measured, asynchronous to sysclk (for example, a divided clock).
REQ-006 rise_tick  output  1  one-cycle pulse per detected clkin rising edge.
REQ-007 fall_tick  output  1  one-cycle pulse per detected clkin falling edge.
REQ-008 period  output  CNT_W  last measured clkin period in sysclk cycles (rise to rise).
REQ-009 high_time  output  CNT_W  last measured high phase in sysclk cycles (rise to fall).
REQ-010 valid  output  1  high when period and high_time hold a measurement from the current lock.
REQ-011 stalled  output  1  sticky timeout flag.

Function
REQ-012 clkin SHALL pass through a two-flop synchronizer followed by a history flop; edge detection SHALL compare the second synchronizer flop with the history flop.
REQ-013 rise_tick/fall_tick SHALL assert exactly 3 sysclk edges after the sysclk edge that first samples the new clkin level, for exactly 1 cycle per edge.
REQ-014 Free counter cnt (CNT_W bits) SHALL clear to 0 on the cycle rise_tick is high, else increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-015 Elapsed time at a detect cycle SHALL be defined as cnt+1, saturated to 2^CNT_W-1.
REQ-016 FSM states: IDLE (no rise since reset/timeout), ARMED (one rise seen), LOCKED (two or more rises seen).
REQ-017 IDLE: on rise_tick -> ARMED; clear cnt; period, high_time and valid unchanged; clear stalled.
REQ-018 ARMED: on fall_tick, latch high_time <= elapsed; on rise_tick, latch period <= elapsed, set valid=1 on the next cycle, -> LOCKED.
REQ-019 LOCKED: on each rise_tick, update period; on each fall_tick, update high_time; valid stays 1.
REQ-020 A fall_tick in IDLE SHALL be ignored.
REQ-021 Timeout: in ARMED or LOCKED, when cnt reaches TIMEOUT-1 with no rise_tick in that cycle, the block SHALL go to IDLE, set valid=0 and set stalled=1 in the same update; period and high_time SHALL hold their last values.
REQ-022 Simultaneous events: rise_tick and timeout in the same cycle SHALL give priority to rise_tick (no timeout).
REQ-023 rise_tick and fall_tick SHALL never be high in the same cycle, because both are derived from one synchronized sample pair.
REQ-024 Measurements are exact for clkin phases of at least 2 sysclk cycles; shorter phases may be missed and SHALL NOT cause an illegal FSM state.

Reset
REQ-025 While resetn=0 the following SHALL be forced low:
- all synchronizer and history flops;
- cnt;
- rise_tick and fall_tick;
- period and high_time;
- valid and stalled.
REQ-026 While resetn=0 the FSM SHALL be forced to IDLE.
REQ-027 Deassertion of resetn SHALL take effect on the first sysclk edge after release; a clkin level of 1 at release SHALL produce a rise_tick, which arms the meter.
REQ-028 Reset asserted mid-measurement SHALL discard all partial state; no stale value SHALL appear after release.

Verification
REQ-029 Lock test: clkin square wave, 8-cycle period, 4 high -> first rise_tick 3 cycles after the first sampled rise; valid=1 the cycle after the second rise_tick; period=8, high_time=4.
REQ-030 Duty test: period 10, high 3 -> period=10, high_time=3 updated every period; fall_tick count equals rise_tick count ±1.
REQ-031 Timeout test: TIMEOUT=50, lock at period 8, then hold clkin low -> stalled=1, valid=0 when cnt reaches 49; period stays 8. Restart the clock -> stalled=0 on the first rise, valid=1 on the second.
REQ-032 Reset mid-operation: lock at period 8, pulse resetn low for 2 cycles -> all outputs 0 and FSM in IDLE; relock gives period=8.
REQ-033 Saturation test: CNT_W=6, TIMEOUT=63, two rises 100 cycles apart -> timeout fires, valid=0, no wrap in cnt.
REQ-034 Boundary test: period 4, high 2 -> period=4, high_time=2; one-cycle clkin glitch -> no FSM corruption; rise/fall never coincident.
